// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: request and control signals between the pipeline stages and pipe_ctrl.
// The master side issues stall/multi-cycle/exception requests; the slave is the controller.
interface pipe_ctrl_if #(
   parameter int MC_W  = 5,
   parameter int CNT_W = 16
);
   logic             stallreq_id;
   logic             stallreq_ex;
   logic             mc_start;
   logic [MC_W-1:0]  mc_cycles;
   logic             excp_valid;
   logic [31:0]      excp_handler;
   logic             stall_cnt_clr;
   logic [5:0]       stall;
   logic             flush;
   logic [31:0]      new_pc;
   logic             mc_done;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output stallreq_id, stallreq_ex, mc_start, mc_cycles, excp_valid, excp_handler, stall_cnt_clr,
      input  stall, flush, new_pc, mc_done, stall_cnt
   );

   modport slave (
      input  stallreq_id, stallreq_ex, mc_start, mc_cycles, excp_valid, excp_handler, stall_cnt_clr,
      output stall, flush, new_pc, mc_done, stall_cnt
   );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall arbitration, multi-cycle countdown, registered exception flush and stall counter.
// stall/mc_done are combinational; flush/new_pc/stall_cnt are registered.
module pipe_ctrl #(
   parameter int MC_W  = 5,
   parameter int CNT_W = 16
) (
   input logic        clk,
   input logic        rst,
   pipe_ctrl_if.slave bus
);
   typedef enum logic [1:0] {RUN, MC_WAIT, FLUSH} state_t;

   localparam logic [5:0] EX_S = 6'b001111;
   localparam logic [5:0] ID_S = 6'b000111;

   state_t           state, state_nx;
   logic [MC_W-1:0]  cnt, cnt_nx;
   logic [5:0]       stall_c;
   logic             done_c;
   logic             cap;
   logic             flush;
   logic [31:0]      new_pc;
   logic [CNT_W-1:0] stall_cnt;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      stall_c  = '0;
      done_c   = 1'b0;
      cap      = 1'b0;
      if (state == RUN) begin
         if (bus.excp_valid) begin
            cap      = 1'b1;
            state_nx = FLUSH;
         end else if (bus.mc_start && bus.mc_cycles > MC_W'(1)) begin
            stall_c  = EX_S;
            cnt_nx   = bus.mc_cycles - MC_W'(1);
            state_nx = MC_WAIT;
         end else if (bus.mc_start && bus.mc_cycles == MC_W'(1)) begin
            stall_c = EX_S;
            done_c  = 1'b1;
         end else begin
            stall_c = bus.stallreq_ex ? EX_S : bus.stallreq_id ? ID_S : 6'b000000;
         end
      end else if (state == MC_WAIT) begin
         if (bus.excp_valid) begin
            cap      = 1'b1;
            state_nx = FLUSH;
         end else begin
            stall_c  = EX_S;
            cnt_nx   = cnt - MC_W'(1);
            done_c   = (cnt == MC_W'(1));
            state_nx = done_c ? RUN : MC_WAIT;
         end
      end else begin
         state_nx = RUN;
      end
   end

   // Reset overrides the combinational outputs so nothing leaks while rst is high.
   assign bus.stall     = rst ? 6'b000000 : stall_c;
   assign bus.mc_done   = ~rst & done_c;
   assign bus.flush     = flush;
   assign bus.new_pc    = new_pc;
   assign bus.stall_cnt = stall_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= RUN;
         cnt       <= '0;
         flush     <= 1'b0;
         new_pc    <= '0;
         stall_cnt <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         flush <= cap;
         if (cap)
            new_pc <= bus.excp_handler;
         if (bus.stall_cnt_clr)
            stall_cnt <= '0;
         else if (stall_c[0] && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed stimulus pushes hand-computed per-cycle expectations; a monitor checks at negedge.
module tb_pipe_ctrl;
   localparam logic [5:0] EXL = 6'b001111;
   localparam logic [5:0] IDL = 6'b000111;
   localparam logic [5:0] NO  = 6'b000000;

   typedef struct {
      logic [5:0]  stall;
      logic        done;
      logic        fl;
      logic [31:0] pc;
      logic [3:0]  cnt;
      string       nm;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_run = 0;
   int   n_fail = 0;
   exp_t q[$];

   always #5 clk = ~clk;

   pipe_ctrl_if #(.MC_W(5), .CNT_W(4)) b();
   pipe_ctrl #(.MC_W(5), .CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(b));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [5:0] s, input logic d, input logic f, input logic [31:0] p,
                       input logic [3:0] c, input string n);
      exp_t e;
      e.stall = s; e.done = d; e.fl = f; e.pc = p; e.cnt = c; e.nm = n;
      q.push_back(e);
   endtask

   task automatic chk(input string n, input string f, input logic [31:0] got, input logic [31:0] want);
      n_run++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s.%s: got %0h, want %0h", n, f, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk(e.nm, "stall", 32'(b.stall), 32'(e.stall));
         chk(e.nm, "mc_done", 32'(b.mc_done), 32'(e.done));
         chk(e.nm, "flush", 32'(b.flush), 32'(e.fl));
         chk(e.nm, "new_pc", b.new_pc, e.pc);
         chk(e.nm, "stall_cnt", 32'(b.stall_cnt), 32'(e.cnt));
      end
   end

   initial begin
      b.stallreq_id = 0; b.stallreq_ex = 0; b.mc_start = 0; b.mc_cycles = 0;
      b.excp_valid = 0; b.excp_handler = 0; b.stall_cnt_clr = 0;
      tick(); b.stallreq_ex = 1; b.mc_start = 1; b.mc_cycles = 4;
      push(NO, 0, 0, 0, 0, "in_rst");
      tick(); rst = 0; b.stallreq_ex = 0; b.mc_start = 0; b.mc_cycles = 0;
      push(NO, 0, 0, 0, 0, "idle");
      tick(); b.stallreq_id = 1;                    push(IDL, 0, 0, 0, 0, "id_a");
      tick();                                       push(IDL, 0, 0, 0, 1, "id_b");
      tick(); b.stallreq_ex = 1;                    push(EXL, 0, 0, 0, 2, "ex_over_id");
      tick(); b.stallreq_id = 0; b.stallreq_ex = 0; push(NO, 0, 0, 0, 3, "cnt3");
      tick(); b.mc_start = 1; b.mc_cycles = 4;      push(EXL, 0, 0, 0, 3, "mc4_c1");
      tick(); b.mc_start = 0; b.stallreq_id = 1;    push(EXL, 0, 0, 0, 4, "mc4_c2");
      tick(); b.stallreq_id = 0;                    push(EXL, 0, 0, 0, 5, "mc4_c3");
      tick();                                       push(EXL, 1, 0, 0, 6, "mc4_c4");
      tick();                                       push(NO, 0, 0, 0, 7, "mc4_after");
      tick(); b.mc_start = 1; b.mc_cycles = 1;      push(EXL, 1, 0, 0, 7, "mc1");
      tick(); b.mc_start = 0;                       push(NO, 0, 0, 0, 8, "mc1_after");
      tick(); b.mc_start = 1; b.mc_cycles = 0;      push(NO, 0, 0, 0, 8, "mc0");
      tick(); b.mc_start = 0;                       push(NO, 0, 0, 0, 8, "mc0_after");
      tick(); b.excp_valid = 1; b.excp_handler = 32'h40; b.stallreq_ex = 1;
      push(NO, 0, 0, 0, 8, "excp_run");
      tick(); b.excp_handler = 32'h80;              push(NO, 0, 1, 32'h40, 8, "flush");
      tick(); b.excp_valid = 0; b.stallreq_ex = 0;  push(NO, 0, 0, 32'h40, 8, "flush_done");
      tick(); b.mc_start = 1; b.mc_cycles = 10;     push(EXL, 0, 0, 32'h40, 8, "mc10_c1");
      tick(); b.mc_start = 0;                       push(EXL, 0, 0, 32'h40, 9, "mc10_w1");
      tick();                                       push(EXL, 0, 0, 32'h40, 10, "mc10_w2");
      tick(); b.excp_valid = 1; b.excp_handler = 32'h100;
      push(NO, 0, 0, 32'h40, 11, "mc10_abort");
      tick(); b.excp_valid = 0;                     push(NO, 0, 1, 32'h100, 11, "abort_flush");
      tick();                                       push(NO, 0, 0, 32'h100, 11, "abort_run");
      tick();                                       push(NO, 0, 0, 32'h100, 11, "abort_idle");
      tick(); b.stallreq_ex = 1;                    push(EXL, 0, 0, 32'h100, 11, "sat_11");
      tick();                                       push(EXL, 0, 0, 32'h100, 12, "sat_12");
      tick();                                       push(EXL, 0, 0, 32'h100, 13, "sat_13");
      tick();                                       push(EXL, 0, 0, 32'h100, 14, "sat_14");
      tick();                                       push(EXL, 0, 0, 32'h100, 15, "sat_15");
      tick();                                       push(EXL, 0, 0, 32'h100, 15, "sat_hold");
      tick(); b.stall_cnt_clr = 1;                  push(EXL, 0, 0, 32'h100, 15, "clr_req");
      tick(); b.stall_cnt_clr = 0;                  push(EXL, 0, 0, 32'h100, 0, "clr_done");
      tick(); b.stallreq_ex = 0;                    push(NO, 0, 0, 32'h100, 1, "after_clr");
      tick(); b.mc_start = 1; b.mc_cycles = 5;      push(EXL, 0, 0, 32'h100, 1, "mc5_c1");
      tick(); b.mc_start = 0;                       push(EXL, 0, 0, 32'h100, 2, "mc5_w1");
      tick(); #2; rst = 1;                          push(NO, 0, 0, 0, 0, "async_rst");
      tick(); rst = 0;                              push(NO, 0, 0, 0, 0, "post_rst_a");
      tick();                                       push(NO, 0, 0, 0, 0, "post_rst_b");
      tick(); b.excp_valid = 1; b.excp_handler = 32'h200;
      push(NO, 0, 0, 0, 0, "excp2");
      tick(); b.excp_valid = 0; #2; rst = 1;        push(NO, 0, 0, 0, 0, "rst_in_flush");
      tick(); rst = 0;                              push(NO, 0, 0, 0, 0, "post_rst_c");
      for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
      #1;
      if (q.size() > 0) begin
         n_run++;
         n_fail++;
         $display("FAIL drain: got %0d pending, want 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline controller for the 5-stage core. It collects stall requests from the ID stage (load-use hazard) and EX stage (variable-latency ops), and sequences fixed-latency multi-cycle EX operations with an internal countdown. It converts exception requests into a registered one-cycle flush with a redirect PC. It drives the per-stage stall vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb, and keeps a saturating stall-cycle performance counter.

Parameters:
MC_W, 5, width of the multi-cycle length field (maximum length 2^MC_W-1 cycles)
CNT_W, 16, width of the stall performance counter

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  reset; asynchronous, active-high (`RstEnable = 1'b1)
stallreq_id  input  1  ID requests a stall (load-use hazard)
stallreq_ex  input  1  EX requests a stall (variable-latency op in progress)
mc_start  input  1  EX issues a fixed-latency multi-cycle op this cycle
mc_cycles  input  MC_W  total stall length of that op, in cycles
excp_valid  input  1  exception/redirect request
excp_handler  input  32  redirect target PC, sampled with excp_valid
stall  output  6  bit0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb; 1 = hold
flush  output  1  registered one-cycle pipeline flush
new_pc  output  32  redirect PC; valid while flush=1
mc_done  output  1  high on the final stall cycle of a multi-cycle op
stall_cnt  output  CNT_W  count of cycles with stall[0]=1
stall_cnt_clr  input  1  synchronous clear of stall_cnt

Behaviour:
- States: RUN, MC_WAIT, FLUSH. rst=1 forces RUN asynchronously. It also clears mc counter, flush, new_pc, mc_done and stall_cnt to 0. While rst=1, stall=6'b000000, whatever the inputs.
- stall and mc_done are combinational from state and inputs (same-cycle effect). flush and new_pc are registered.
- Stall encodings: EX-level = 6'b001111, ID-level = 6'b000111, none = 6'b000000.
- RUN, priority order (highest first):
  - excp_valid=1: stall=0. Register new_pc<=excp_handler. Next state FLUSH. mc_start, stallreq_* ignored.
  - mc_start=1 with mc_cycles>=2: stall=EX-level. Load counter<=mc_cycles-1. Next state MC_WAIT.
  - mc_start=1 with mc_cycles=1: stall=EX-level and mc_done=1 this cycle only. Stay RUN.
  - mc_start=1 with mc_cycles=0: treated as no mc_start.
  - stallreq_ex=1: stall=EX-level.
  - stallreq_id=1: stall=ID-level.
  - Otherwise: stall=0.
- MC_WAIT:
  - stall=EX-level every cycle. Counter decrements each cycle.
  - When counter=1: mc_done=1 this cycle, next state RUN.
  - Total stalled cycles = mc_cycles, including the start cycle.
  - stallreq_id, stallreq_ex and mc_start are ignored.
  - excp_valid=1: abort the countdown, stall=0, mc_done=0, new_pc<=excp_handler, next state FLUSH.
- FLUSH:
  - flush=1 and stall=0 for exactly one cycle, with new_pc holding the captured target. Next state RUN.
  - excp_valid in FLUSH is ignored; the first redirect wins.
  - flush returns to 0 in RUN. new_pc holds its value until the next capture.
- stall_cnt: +1 on every cycle with stall[0]=1. It saturates at all-ones, no wrap.
  - stall_cnt_clr=1 loads 0, and takes priority over increment in the same cycle.
- Reset mid-MC_WAIT or mid-FLUSH: immediate return to RUN. No residual flush, no mc_done.

Test Plan:
- Reset then idle, no requests -> stall=000000, flush=0, stall_cnt=0. Assert rst asynchronously mid-cycle -> outputs zero before the next edge.
- stallreq_id=1 for 2 cycles, then stallreq_ex=1 with stallreq_id=1 for 1 cycle -> stall=000111, 000111, then 001111; stall_cnt=3.
- mc_start=1, mc_cycles=4 -> stall=001111 for exactly 4 cycles, mc_done=1 only on the 4th; 5th cycle stall=0. Repeat with mc_cycles=1 -> a single stall cycle with mc_done=1; mc_cycles=0 -> no stall.
- excp_valid=1, excp_handler=32'h0000_0040 in RUN -> that cycle stall=0. Next cycle flush=1 and new_pc=0x40. The following cycle flush=0. A second excp_valid during FLUSH is ignored.
- mc_start with mc_cycles=10, then excp_valid on the 3rd cycle of MC_WAIT -> countdown aborted, mc_done never asserted, flush=1 next cycle, then RUN with stall=0.
- Preload stall_cnt near all-ones and hold stallreq_ex -> counter saturates at all-ones. Assert stall_cnt_clr together with a stall -> stall_cnt=0 next cycle.
